// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: next-PC selects, vector addresses,
// and instruction field bit positions.
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PCSRC_W   = 3;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned IMM16_W   = 16;

  typedef enum logic [PCSRC_W-1:0] {
    PCSRC_SEQ = 3'd0,
    PCSRC_BR  = 3'd1,
    PCSRC_J   = 3'd2,
    PCSRC_JR  = 3'd3,
    PCSRC_IRQ = 3'd4,
    PCSRC_EXC = 3'd5
  } pc_src_e;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0] ILLOP_PC_DEF = 32'h8000_0004;
  localparam logic [XLEN-1:0] XADR_PC_DEF  = 32'h8000_0008;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned TARGET_W   = 26;

endpackage

// File: rtl/pc_fetch_unit_irq_sync.sv
// External interrupt path: multi-flop synchroniser, rising-edge detect and a
// pending latch that holds the request until the core takes it.
module pc_fetch_unit_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clear,
  input  logic enable,
  output logic irq_req
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   pending_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

  // A new edge arriving with the clear keeps the request pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      last_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
      last_q    <= sync_q[SYNC_STAGES-1];
      pending_q <= rise | (pending_q & ~clear);
    end
  end

  assign irq_req = pending_q & enable;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, link value,
// retired-cycle counter, instruction field slicing and gated interrupt request.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [XLEN-1:0] ILLOP_PC    = ILLOP_PC_DEF,
  parameter logic [XLEN-1:0] XADR_PC     = XADR_PC_DEF,
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                irq_in,
  input  logic [XLEN-1:0]     inst_data,
  input  logic [PCSRC_W-1:0]  pc_src,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     rs_data,
  input  logic [XLEN-1:0]     imm_ext,
  output logic [XLEN-1:0]     inst_addr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT_W-1:0]  funct,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    shamt,
  output logic [IMM16_W-1:0]  imm16,
  output logic                irq_to_ctrl,
  output logic [XLEN-1:0]     link_pc,
  output logic [XLEN-1:0]     retired
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-2:0] br_offset;
  logic            irq_clear;

  // Supervisor bit is carried through; only the low 31 bits advance.
  assign pc_plus4  = {pc_q[XLEN-1], pc_q[XLEN-2:0] + (XLEN-1)'(4)};
  assign br_offset = (XLEN-1)'({imm_ext[28:0], 2'b00});

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_SEQ: next_pc = pc_plus4;
      PCSRC_BR:  next_pc = branch_taken ? {pc_q[XLEN-1], pc_plus4[XLEN-2:0] + br_offset}
                                        : pc_plus4;
      PCSRC_J:   next_pc = {pc_plus4[XLEN-1:XLEN-4], inst_data[TARGET_W-1:0], 2'b00};
      // jr can leave kernel mode but never enter it.
      PCSRC_JR:  next_pc = {pc_q[XLEN-1] & rs_data[XLEN-1], rs_data[XLEN-2:0]};
      PCSRC_IRQ: next_pc = ILLOP_PC;
      PCSRC_EXC: next_pc = XADR_PC;
      default:   next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      retired <= '0;
    end else if (!stall) begin
      pc_q    <= next_pc;
      retired <= retired + XLEN'(1);
    end
  end

  // An interrupt re-executes the interrupted instruction on return.
  assign link_pc   = (pc_src == PCSRC_IRQ) ? pc_q : pc_plus4;
  assign inst_addr = pc_q;

  assign opcode = inst_data[OPCODE_LSB +: OPCODE_W];
  assign rs     = inst_data[RS_LSB     +: REG_W];
  assign rt     = inst_data[RT_LSB     +: REG_W];
  assign rd     = inst_data[RD_LSB     +: REG_W];
  assign shamt  = inst_data[SHAMT_LSB  +: REG_W];
  assign funct  = inst_data[FUNCT_LSB  +: FUNCT_W];
  assign imm16  = inst_data[IMM16_W-1:0];

  assign irq_clear = ~stall & (pc_src == PCSRC_IRQ);

  pc_fetch_unit_irq_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .clear   (irq_clear),
    .enable  (~pc_q[XLEN-1]),
    .irq_req (irq_to_ctrl)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequencing, branch, jump, jr,
// interrupt latency/take/kernel hold, stall and PC wrap.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        irq_in;
  logic [31:0] inst_data;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] rs_data;
  logic [31:0] imm_ext;
  logic [31:0] inst_addr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic        irq_to_ctrl;
  logic [31:0] link_pc;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .irq_in       (irq_in),
    .inst_data    (inst_data),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .rs_data      (rs_data),
    .imm_ext      (imm_ext),
    .inst_addr    (inst_addr),
    .opcode       (opcode),
    .funct        (funct),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .imm16        (imm16),
    .irq_to_ctrl  (irq_to_ctrl),
    .link_pc      (link_pc),
    .retired      (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge; the retired model follows reset/stall as seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) exp_ret = 0;
    else if (!stall) exp_ret = exp_ret + 1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic jr_to(input logic [31:0] target);
    pc_src  = 3'd3;
    rs_data = target;
    tick();
    pc_src  = 3'd0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; irq_in = 1'b0; inst_data = 32'h0;
    pc_src = 3'd0; branch_taken = 1'b0; rs_data = 32'h0; imm_ext = 32'h0;

    // Reset state and sequential fetch
    do_reset();
    check("reset_pc", inst_addr, 32'h8000_0000);
    check("reset_retired", retired, 32'h0);
    check("reset_irq", {31'h0, irq_to_ctrl}, 32'h0);
    check("link_seq", link_pc, 32'h8000_0004);
    for (int i = 0; i < 3; i++) tick();
    check("seq_pc", inst_addr, 32'h8000_000C);
    check("seq_retired", retired, 32'd3);

    // Field slicing
    inst_data = 32'hAFBF_0010;
    #1;
    check("opcode", {26'h0, opcode}, 32'h2B);
    check("rs", {27'h0, rs}, 32'h1D);
    check("rt", {27'h0, rt}, 32'h1F);
    check("rd", {27'h0, rd}, 32'h0);
    check("shamt", {27'h0, shamt}, 32'h0);
    check("funct", {26'h0, funct}, 32'h10);
    check("imm16", {16'h0, imm16}, 32'h0010);

    // Branch taken / not taken with negative offset
    jr_to(32'h0000_0100);
    check("jr_user", inst_addr, 32'h0000_0100);
    pc_src = 3'd1; imm_ext = 32'hFFFF_FFFE; branch_taken = 1'b1;
    tick();
    check("br_taken", inst_addr, 32'h0000_00FC);
    jr_to(32'h0000_0100);
    pc_src = 3'd1; branch_taken = 1'b0;
    tick();
    check("br_not_taken", inst_addr, 32'h0000_0104);
    pc_src = 3'd0;

    // jr cannot enter kernel from user; kernel may target kernel
    jr_to(32'h0040_0000);
    jr_to(32'h8000_0010);
    check("jr_user_no_kernel", inst_addr, 32'h0000_0010);
    do_reset();
    jr_to(32'h8000_0010);
    check("jr_kernel", inst_addr, 32'h8000_0010);

    // Interrupt latency in user mode, then take it
    jr_to(32'h0000_0020);
    stall = 1'b1;
    irq_in = 1'b1;
    tick();
    check("irq_lat_e1", {31'h0, irq_to_ctrl}, 32'h0);
    tick();
    check("irq_lat_e2", {31'h0, irq_to_ctrl}, 32'h0);
    tick();
    check("irq_lat_e3", {31'h0, irq_to_ctrl}, 32'h1);
    check("stall_hold_pc", inst_addr, 32'h0000_0020);
    stall = 1'b0;
    pc_src = 3'd4;
    #1;
    check("link_irq", link_pc, 32'h0000_0020);
    tick();
    pc_src = 3'd0;
    check("irq_vector", inst_addr, 32'h8000_0004);
    jr_to(32'h0000_0300);
    check("irq_cleared", {31'h0, irq_to_ctrl}, 32'h0);
    irq_in = 1'b0;
    tick();
    tick();

    // Kernel-mode hold: pending survives until return to user
    do_reset();
    jr_to(32'h8000_0040);
    stall = 1'b1;
    irq_in = 1'b1;
    tick();
    tick();
    irq_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("kernel_irq_masked", {31'h0, irq_to_ctrl}, 32'h0);
    stall = 1'b0;
    jr_to(32'h0000_0200);
    check("kernel_jr_user", inst_addr, 32'h0000_0200);
    check("irq_after_return", {31'h0, irq_to_ctrl}, 32'h1);
    pc_src = 3'd4;
    tick();
    pc_src = 3'd0;
    check("irq_vector2", inst_addr, 32'h8000_0004);

    // Exception vector and its link value
    jr_to(32'h0000_0100);
    pc_src = 3'd5;
    #1;
    check("link_exc", link_pc, 32'h0000_0104);
    tick();
    check("exc_vector", inst_addr, 32'h8000_0008);

    // Stall ignores a pending jump; release takes it
    jr_to(32'h0000_0100);
    inst_data = 32'h0800_0123;
    pc_src = 3'd2;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("stall_pc", inst_addr, 32'h0000_0100);
    check("stall_retired", retired, exp_ret);
    stall = 1'b0;
    tick();
    check("jump_taken", inst_addr, 32'h0000_048C);
    check("retired_count", retired, exp_ret);
    pc_src = 3'd0;

    // Low 31-bit wrap
    do_reset();
    jr_to(32'h7FFF_FFFC);
    check("pre_wrap", inst_addr, 32'h7FFF_FFFC);
    tick();
    check("pc_wrap", inst_addr, 32'h0000_0000);
    pc_src = 3'd6;
    tick();
    check("pcsrc6_seq", inst_addr, 32'h0000_0004);
    pc_src = 3'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
